// File: rtl/mux5_reg.sv
// Registered 5:1 word multiplexer for datapath source selection.
// The select code is decoded to a one-hot enable, and each source passes
// through its own gating lane. Every bit of an unselected source is ANDed
// with zero, so X or Z on an unused source cannot reach out.
// Codes 5..7 enable no lane, which yields all-zeros and raises sel_err
// alongside out_valid.

// One gating lane: passes src when en is high, forces zeros otherwise.
module mux5_lane #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] gated
);

    assign gated = src & {WIDTH{en}};

endmodule

module mux5_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [WIDTH-1:0] src3,
    input  logic [WIDTH-1:0] src4,
    input  logic [WIDTH-1:0] src5,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_err
);

    localparam int NUM_SRC = 5;

    logic [NUM_SRC-1:0][WIDTH-1:0] srcs;
    logic [NUM_SRC-1:0][WIDTH-1:0] gated;
    logic [NUM_SRC-1:0]            onehot;
    logic [WIDTH-1:0]              mux_word;
    logic                          sel_bad;

    // Index i of srcs holds the source chosen by select code i.
    assign srcs    = {src5, src4, src3, src2, src1};
    assign sel_bad = (select > 3'd4);

    // Decode the select code to a one-hot lane enable; codes 5..7 enable nothing.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (select == 3'(i)) onehot[i] = 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_lane
            mux5_lane #(.WIDTH(WIDTH)) u_lane (
                .en    (onehot[g]),
                .src   (srcs[g]),
                .gated (gated[g])
            );
        end
    endgenerate

    // OR the gated lanes together; at most one lane is non-zero.
    always_comb begin
        mux_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            mux_word = mux_word | gated[i];
        end
    end

    // Output register: reset wins, otherwise capture on in_valid or hold the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (in_valid) begin
            out       <= mux_word;
            out_valid <= 1'b1;
            sel_err   <= sel_bad;
        end else begin
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux5_reg.sv
// Directed bench for mux5_reg. Inputs are changed between edges, and outputs
// are sampled 1 time unit after each rising edge.
module tb_mux5_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  select;
    logic [31:0] src1, src2, src3, src4, src5;
    logic [31:0] out;
    logic        out_valid;
    logic        sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    mux5_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .select    (select),
        .src1      (src1),
        .src2      (src2),
        .src3      (src3),
        .src4      (src4),
        .src5      (src5),
        .out       (out),
        .out_valid (out_valid),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [31:0] eo, input logic ev, input logic ee);
        chk({tag, ".out"}, out, eo);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".sel_err"}, {31'd0, sel_err}, {31'd0, ee});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; select = 3'd1;
        src1 = 32'd50; src2 = 32'd10; src3 = 32'd128; src4 = 32'd998; src5 = 32'd225;

        // Reset held for two edges while in_valid is high.
        step(); chk3("rst0", 32'd0, 1'b0, 1'b0);
        step(); chk3("rst1", 32'd0, 1'b0, 1'b0);

        // Release reset; capture resumes on the next edge.
        rst = 1'b0;
        step(); chk3("rel", 32'd10, 1'b1, 1'b0);

        // Full sweep of the valid select codes, back to back.
        select = 3'd1; step(); chk3("sw1", 32'd10,  1'b1, 1'b0);
        select = 3'd0; step(); chk3("sw0", 32'd50,  1'b1, 1'b0);
        select = 3'd3; step(); chk3("sw3", 32'd998, 1'b1, 1'b0);
        select = 3'd2; step(); chk3("sw2", 32'd128, 1'b1, 1'b0);
        select = 3'd4; step(); chk3("sw4", 32'd225, 1'b1, 1'b0);

        // Invalid select codes give zeros with sel_err.
        select = 3'd5; step(); chk3("bad5", 32'd0, 1'b1, 1'b1);
        select = 3'd6; step(); chk3("bad6", 32'd0, 1'b1, 1'b1);
        select = 3'd7; step(); chk3("bad7", 32'd0, 1'b1, 1'b1);
        select = 3'd2; step(); chk3("rec2", 32'd128, 1'b1, 1'b0);

        // Hold: capture 998, then drop in_valid and disturb the inputs.
        select = 3'd3; step(); chk3("cap3", 32'd998, 1'b1, 1'b0);
        in_valid = 1'b0; select = 3'd4; src4 = 32'd7;
        step(); chk3("hold", 32'd998, 1'b0, 1'b0);
        select = 3'bxxx; src2 = 32'hxxxx_xxxx;
        step(); chk3("holdx", 32'd998, 1'b0, 1'b0);
        src2 = 32'd10;

        // An X on an unused source must not reach out.
        in_valid = 1'b1; select = 3'd2; src1 = 32'hxxxx_xxxx;
        step(); chk3("xunused", 32'd128, 1'b1, 1'b0);
        src1 = 32'd50;

        // Reset on the same edge as a capture discards that capture.
        select = 3'd4; rst = 1'b1;
        step(); chk3("midrst", 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk3("after", 32'd225, 1'b1, 1'b0);

        // Width boundary: an all-ones word passes through unmodified.
        src3 = 32'hFFFF_FFFF; select = 3'd2;
        step(); chk3("wide", 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Dropping in_valid after the all-ones capture holds the word.
        in_valid = 1'b0;
        step(); chk3("widehold", 32'hFFFF_FFFF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux5_reg.md
Name: mux5_reg

Overview:
- Registered 5:1 word multiplexer for datapath source selection, e.g. ALU operand or write-back source.
- Combinational select among five WIDTH-bit sources, captured into an output register on the rising clock edge.
- Provides an output-valid flag and a select-error flag for select codes outside 0..4.

Parameters:
- WIDTH, 32, bit width of each source and of the output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  when high, the current select and sources are captured this edge.
- select  input  3  source select code.
- src1  input  WIDTH  source for select=0.
- src2  input  WIDTH  source for select=1.
- src3  input  WIDTH  source for select=2.
- src4  input  WIDTH  source for select=3.
- src5  input  WIDTH  source for select=4.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  high for one cycle after each capture.
- sel_err  output  1  high alongside out_valid when the captured select was 5, 6 or 7.

Behaviour:
- Reset: on a rising edge with rst=1, out=0, out_valid=0 and sel_err=0.
  - Reset has priority over in_valid.
  - Reset asserted mid-stream discards the pending capture.
- Decode is combinational:
  - 0 selects src1, 1 selects src2, 2 selects src3, 3 selects src4, 4 selects src5.
  - 5, 6 and 7 select all-zeros.
- Capture: on a rising edge with rst=0 and in_valid=1:
  - out takes the decoded word.
  - out_valid is set to 1.
  - sel_err is set to 1 if select > 4, otherwise 0.
- Hold: on a rising edge with rst=0 and in_valid=0:
  - out holds its previous value.
  - out_valid is set to 0.
  - sel_err is set to 0.
- Latency: exactly 1 cycle from the in_valid edge to out/out_valid.
  - Throughput is one capture per cycle.
  - Back-to-back in_valid gives a continuous out_valid.
- Source changes between edges have no effect on out. Only the values present at the capture edge matter.
- Data is passed unmodified: no sign extension, arithmetic or truncation.
- No X propagation from unused sources: only the selected source influences out.
- Select or source X/Z during in_valid=0 must not disturb any output.

Test Plan:
- Reset:
  - Assert rst for 2 cycles with in_valid=1, select=1 -> out=0, out_valid=0, sel_err=0.
  - Release rst -> capture resumes on the next edge.
- Full sweep:
  - Sources are src1=50, src2=10, src3=128, src4=998, src5=225, with in_valid=1.
  - Apply select 1,0,3,2,4 on consecutive cycles -> out is 10, 50, 998, 128, 225, each one cycle later.
  - out_valid=1 throughout and sel_err=0.
- Invalid select: select=5, then 6, then 7 with in_valid=1 -> out=0 and sel_err=1 for each, one cycle later.
  - A following select=2 -> out=128 and sel_err=0.
- Hold:
  - Capture select=3 (out=998), then drop in_valid.
  - Change select to 4 and src4 to 7 -> out stays 998, out_valid=0 and sel_err=0.
- Reset mid-stream:
  - With in_valid=1 and select=4, assert rst on the same edge -> out=0 and out_valid=0.
  - Next edge with rst=0 -> out=225.
- Width boundary: src3=32'hFFFF_FFFF, select=2 -> out=32'hFFFF_FFFF exactly.
